// File: rtl/div_radix2_pkg.sv
// Shared types for the radix-2 restoring divider.
// FSM state encoding and counter-width helper.
package div_radix2_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // Counter width; never below one bit.
  function automatic int div_cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division iteration: shift {rem, dvd} left,
// trial-subtract the divisor, keep or restore, emit quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   dvs_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               qbit_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Shifted remainder keeps the bit shifted out of the top.
  assign trial  = acc_i[2*WIDTH-1:WIDTH-1];
  assign diff   = trial - {1'b0, dvs_i};
  assign qbit_o = ~diff[WIDTH];

  assign acc_o = {
    qbit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0],
    acc_i[WIDTH-2:0],
    qbit_o
  };

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero completes in one cycle.
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sign,
  input  logic               opn_valid,
  input  logic               res_ready,
  output logic               res_valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = div_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   a_q;
  logic               qneg_q;
  logic               rneg_q;
  logic               qbit;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   rem_f;
  logic [WIDTH-1:0]   quo_f;
  logic [2*WIDTH-1:0] res_fix;
  logic [WIDTH-1:0]   ones;

  assign ones = {WIDTH{1'b1}};

  // Magnitudes only for signed operations.
  assign abs_a = (sign && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sign && b[WIDTH-1]) ? -b : b;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i (acc_q),
    .dvs_i (dvs_q),
    .acc_o (acc_d),
    .qbit_o(qbit)
  );

  // Sign fix on the final iteration; zero divisor gives a fixed value.
  always_comb begin
    rem_f   = acc_d[2*WIDTH-1:WIDTH];
    quo_f   = {acc_d[WIDTH-1:1], qbit};
    res_fix = {rneg_q ? -rem_f : rem_f,
               qneg_q ? -quo_f : quo_f};
    if (dvs_q == '0) begin
      res_fix = {a_q, ones};
    end
  end

  // Control FSM with registered result and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      dvs_q     <= '0;
      a_q       <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      res_valid <= 1'b0;
      result    <= '0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (opn_valid) begin
            a_q    <= a;
            dvs_q  <= abs_b;
            acc_q  <= {{WIDTH{1'b0}}, abs_a};
            qneg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q <= sign & a[WIDTH-1];
            cnt_q  <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (b == '0) begin
              result    <= {a, ones};
              res_valid <= 1'b1;
              state_q   <= DIV_DONE;
            end else begin
              state_q <= DIV_BUSY;
            end
`else
            state_q <= DIV_BUSY;
`endif
          end
        end
        DIV_BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result    <= res_fix;
            res_valid <= 1'b1;
            state_q   <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            state_q   <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: vector table, scoreboard queue,
// plus backpressure and mid-operation reset sequences.
module tb_div_radix2;

  localparam int W = 32;
  localparam int LAT = W + 1;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W + 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sign;
  logic           opn_valid;
  logic           res_ready;
  logic           res_valid;
  logic [2*W-1:0] result;

  int n_chk = 0;
  int n_fail = 0;

  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic           s;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] r;
    string          nm;
  } vec_t;

  vec_t vt[12];

  div_radix2 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sign     (sign),
    .opn_valid(opn_valid),
    .res_ready(res_ready),
    .res_valid(res_valid),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns in the
  // first cycle where res_valid is seen.
  task automatic do_op(input logic s, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [2*W-1:0] ev,
                       input int lat, input string nm);
    int cyc;
    logic [2*W-1:0] e;
    sign = s;
    a = av;
    b = bv;
    opn_valid = 1'b1;
    exp_q.push_back(ev);
    @(posedge clk);
    #1;
    opn_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sign = 1'($urandom);
    cyc = 1;
    while (!res_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, "_lat"}, 64'(cyc), 64'(lat));
    e = exp_q.pop_front();
    chk({nm, "_res"}, result, e);
  endtask

  initial begin
    vt[0]  = '{1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},                "divu_100_7"};
    vt[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},   "div_m7_2"};
    vt[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000},   "div_ovf"};
    vt[3]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h00000000},   "divu_ovf"};
    vt[4]  = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD},   "div_7_m2"};
    vt[5]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E},   "div_m100_m7"};
    vt[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'h00000000, 32'hFFFFFFFF},   "divu_max_1"};
    vt[7]  = '{1'b0, 32'h12345678,   32'd0,        {32'h12345678, 32'hFFFFFFFF},   "divu_zero"};
    vt[8]  = '{1'b1, 32'h80000000,   32'd0,        {32'h80000000, 32'hFFFFFFFF},   "div_zero"};
    vt[9]  = '{1'b0, 32'd5,          32'd9,        {32'd5, 32'd0},                 "divu_small"};
    vt[10] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, {32'd0, 32'd1},                 "divu_eq"};
    vt[11] = '{1'b1, 32'hFFFFFFFF,   32'd0,        {32'hFFFFFFFF, 32'hFFFFFFFF},   "div_m1_zero"};

    rst = 1'b1;
    a = '0;
    b = '0;
    sign = 1'b0;
    opn_valid = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    rst = 1'b0;

    // Table: each result is accepted on the edge after it appears.
    for (int i = 0; i < 12; i++) begin
      do_op(vt[i].s, vt[i].a, vt[i].b, vt[i].r,
            (vt[i].b == '0) ? ZLAT : LAT, vt[i].nm);
      @(posedge clk);
      #1;
      chk({vt[i].nm, "_drop"}, 64'(res_valid), 64'd0);
    end

    // Backpressure: hold for 5 cycles, then release.
    res_ready = 1'b0;
    do_op(1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, LAT, "bp");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 64'(res_valid), 64'd1);
      chk("bp_hold_res", result, {32'd10, 32'd30});
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drop", 64'(res_valid), 64'd0);
    do_op(1'b1, 32'hFFFFFC18, 32'd33,
          {32'hFFFFFFF6, 32'hFFFFFFE2}, LAT, "b2b");
    @(posedge clk);
    #1;
    chk("b2b_drop", 64'(res_valid), 64'd0);

    // Reset pulse on the tenth iteration edge aborts the operation.
    sign = 1'b0;
    a = 32'd77;
    b = 32'd5;
    opn_valid = 1'b1;
    @(posedge clk);
    #1;
    opn_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_valid", 64'(res_valid), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        #1;
        if (res_valid) seen++;
      end
      chk("abort_no_result", 64'(seen), 64'd0);
    end
    do_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, LAT, "post_rst");
    @(posedge clk);
    #1;
    chk("post_rst_drop", 64'(res_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
